// File: rtl/cnn_pkg.sv
// Shared types, widths and helpers for the CNN accelerator datapath.
// Used by the fully-connected layer engine and its MAC unit.
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int ACC_W  = 40;

  localparam logic [ADDR_W-1:0] FC_IN_BASE = 16'd59596;
  localparam logic [ADDR_W-1:0] FC_W_BASE  = 16'd59716;

  typedef enum logic [2:0] {
    FC_IDLE,
    FC_LOAD_X,
    FC_LOAD_WAIT,
    FC_BIAS,
    FC_MAC,
    FC_DRAIN,
    FC_WRITE,
    FC_DONE
  } fc_state_t;

  // Drop the fraction bits, then clamp into the signed 16-bit range.
  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] acc,
                                                     input int frac);
    logic signed [ACC_W-1:0] s;
    s = acc >>> frac;
    if (s > 40'sd32767)       return 16'sh7fff;
    else if (s < -40'sd32768) return 16'sh8000;
    else                      return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Signed 16x16 multiply with a 40-bit accumulator.
// clear zeroes, load seeds with the aligned bias, acc_en adds a*b.
module fc_mac
  import cnn_pkg::*;
#(
  parameter int FRAC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc_next
);

  logic [ACC_W-1:0]             acc;
  logic signed [2*DATA_W-1:0]   prod;

  assign prod = $signed(a) * $signed(b);

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    acc_next = acc;
    if (clear)
      acc_next = '0;
    else if (load)
      acc_next = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC;
    else if (acc_en)
      acc_next = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc <= '0;
    else       acc <= acc_next;
  end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected layer engine: out[j] = bias[j] + sum_i W[j][i]*x[i], written back
// to RAM, with argmax of the saturated outputs reported on done.
module fc_layer
  import cnn_pkg::*;
#(
  parameter int N_IN  = 120,
  parameter int N_OUT = 10,
  parameter int FRAC  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         in_base,
  input  logic [ADDR_W-1:0]         w_base,
  input  logic [ADDR_W-1:0]         b_base,
  input  logic [ADDR_W-1:0]         out_base,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(N_OUT)-1:0]  class_idx,
  output logic [DATA_W-1:0]         max_value,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IW = $clog2(N_IN);
  localparam int JW = $clog2(N_OUT);
  localparam logic [IW-1:0] LAST_K = IW'(N_IN - 1);
  localparam logic [JW-1:0] LAST_J = JW'(N_OUT - 1);

  fc_state_t         state;
  logic [IW-1:0]     cnt;
  logic [JW-1:0]     j;
  logic [ADDR_W-1:0] b_base_r;
  logic [ADDR_W-1:0] out_base_r;
  logic [ADDR_W-1:0] w_ptr;
  logic [JW-1:0]     best_idx;
  logic [DATA_W-1:0] best_val;

  logic [DATA_W-1:0] xbuf [N_IN];
  logic              xbuf_we;
  logic [IW-1:0]     xbuf_wi;
  logic [IW-1:0]     xsel;

  logic              mac_clear;
  logic              mac_load;
  logic              mac_acc;
  logic [ACC_W-1:0]  acc_sum;

  logic [JW-1:0]     nidx;
  logic [DATA_W-1:0] nval;

  // Read data lags the issue by one cycle, so captures trail the load counter.
  always_comb begin
    xbuf_we = 1'b0;
    xbuf_wi = '0;
    if (state == FC_LOAD_X && cnt != '0) begin
      xbuf_we = 1'b1;
      xbuf_wi = cnt - IW'(1);
    end else if (state == FC_LOAD_WAIT) begin
      xbuf_we = 1'b1;
      xbuf_wi = LAST_K;
    end
  end

  // NOTE: the x buffer is plain storage with no reset; it is always filled before use.
  always_ff @(posedge clk) begin
    if (xbuf_we) xbuf[xbuf_wi] <= mem_rdata;
  end

  always_comb begin
    xsel      = '0;
    if (state == FC_DRAIN)   xsel = LAST_K;
    else if (cnt != '0)      xsel = cnt - IW'(1);
    mac_clear = (state == FC_IDLE) && start;
    mac_load  = (state == FC_MAC) && (cnt == '0);
    mac_acc   = ((state == FC_MAC) && (cnt != '0)) || (state == FC_DRAIN);
  end

  fc_mac #(.FRAC(FRAC)) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clear    (mac_clear),
    .load     (mac_load),
    .acc_en   (mac_acc),
    .bias     (mem_rdata),
    .a        (mem_rdata),
    .b        (xbuf[xsel]),
    .acc_next (acc_sum)
  );

  // Running argmax; output 0 always seeds, strict > keeps the lowest index on ties.
  always_comb begin
    nidx = best_idx;
    nval = best_val;
    if (j == '0 || $signed(mem_wdata) > $signed(best_val)) begin
      nidx = j;
      nval = mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FC_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      class_idx  <= '0;
      max_value  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cnt        <= '0;
      j          <= '0;
      b_base_r   <= '0;
      out_base_r <= '0;
      w_ptr      <= '0;
      best_idx   <= '0;
      best_val   <= '0;
    end else begin
      case (state)
        FC_IDLE: begin
          if (start) begin
            b_base_r   <= b_base;
            out_base_r <= out_base;
            w_ptr      <= w_base;
            mem_addr   <= in_base;
            mem_en     <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
            j          <= '0;
            state      <= FC_LOAD_X;
          end
        end
        FC_LOAD_X: begin
          if (cnt == LAST_K) begin
            mem_en <= 1'b0;
            state  <= FC_LOAD_WAIT;
          end else begin
            cnt      <= cnt + IW'(1);
            mem_addr <= mem_addr + 16'd1;
          end
        end
        FC_LOAD_WAIT: begin
          mem_en   <= 1'b1;
          mem_addr <= b_base_r + ADDR_W'(j);
          state    <= FC_BIAS;
        end
        FC_BIAS: begin
          mem_addr <= w_ptr;
          w_ptr    <= w_ptr + 16'd1;
          cnt      <= '0;
          state    <= FC_MAC;
        end
        FC_MAC: begin
          // Weights are row-major, so one pointer walks all rows back to back.
          if (cnt == LAST_K) begin
            mem_en <= 1'b0;
            state  <= FC_DRAIN;
          end else begin
            cnt      <= cnt + IW'(1);
            mem_addr <= w_ptr;
            w_ptr    <= w_ptr + 16'd1;
          end
        end
        FC_DRAIN: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= out_base_r + ADDR_W'(j);
          mem_wdata <= sat16(acc_sum, FRAC);
          state     <= FC_WRITE;
        end
        FC_WRITE: begin
          mem_we   <= 1'b0;
          best_idx <= nidx;
          best_val <= nval;
          if (j == LAST_J) begin
            mem_en    <= 1'b0;
            done      <= 1'b1;
            class_idx <= nidx;
            max_value <= nval;
            state     <= FC_DONE;
          end else begin
            j        <= j + JW'(1);
            mem_addr <= b_base_r + ADDR_W'(j) + 16'd1;
            state    <= FC_BIAS;
          end
        end
        FC_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= FC_IDLE;
        end
        default: state <= FC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer.sv
// Self-checking bench for fc_layer: table-driven vectors on 4x3 instances (FRAC 0 and 8),
// protocol and mid-run reset sequences, and a randomised 120x10 run against a model.
module tb_fc_layer;
  import cnn_pkg::*;

  typedef struct packed {
    logic [1:0]        sel;
    logic [15:0]       ib, wb, bb, ob;
    logic [3:0][15:0]  x;
    logic [11:0][15:0] w;
    logic [2:0][15:0]  b;
    logic [2:0][15:0]  o;
    logic [1:0]        idx;
    logic [15:0]       mx;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ib, wb, bb, ob;
  logic        start_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        en_v    [3];
  logic        we_v    [3];
  logic [15:0] addr_v  [3];
  logic [15:0] wd_v    [3];
  logic [15:0] rd_v    [3];
  logic [15:0] mx_v    [3];
  logic [1:0]  ci0, ci1;
  logic [3:0]  ci2;

  logic        ld_en;
  logic [1:0]  ld_sel;
  logic [15:0] ld_addr, ld_data;
  logic [15:0] ram [3][65536];

  logic [1:0]  sel;
  logic        busy, done, m_en, m_we;
  logic [15:0] m_addr, m_wd, mx;
  logic [3:0]  ci;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fc_layer #(.N_IN(4), .N_OUT(3), .FRAC(0)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]),
    .in_base(ib), .w_base(wb), .b_base(bb), .out_base(ob),
    .busy(busy_v[0]), .done(done_v[0]), .class_idx(ci0), .max_value(mx_v[0]),
    .mem_en(en_v[0]), .mem_we(we_v[0]), .mem_addr(addr_v[0]),
    .mem_wdata(wd_v[0]), .mem_rdata(rd_v[0])
  );

  fc_layer #(.N_IN(4), .N_OUT(3), .FRAC(8)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]),
    .in_base(ib), .w_base(wb), .b_base(bb), .out_base(ob),
    .busy(busy_v[1]), .done(done_v[1]), .class_idx(ci1), .max_value(mx_v[1]),
    .mem_en(en_v[1]), .mem_we(we_v[1]), .mem_addr(addr_v[1]),
    .mem_wdata(wd_v[1]), .mem_rdata(rd_v[1])
  );

  fc_layer dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]),
    .in_base(ib), .w_base(wb), .b_base(bb), .out_base(ob),
    .busy(busy_v[2]), .done(done_v[2]), .class_idx(ci2), .max_value(mx_v[2]),
    .mem_en(en_v[2]), .mem_we(we_v[2]), .mem_addr(addr_v[2]),
    .mem_wdata(wd_v[2]), .mem_rdata(rd_v[2])
  );

  // One behavioural RAM per instance, 1-cycle read latency, plus a preload port.
  always @(posedge clk) begin
    if (ld_en) ram[ld_sel][ld_addr] <= ld_data;
    for (int k = 0; k < 3; k++) begin
      if (en_v[k]) begin
        if (we_v[k]) ram[k][addr_v[k]] <= wd_v[k];
        rd_v[k] <= ram[k][addr_v[k]];
      end
    end
  end

  always_comb begin
    busy   = busy_v[sel];
    done   = done_v[sel];
    m_en   = en_v[sel];
    m_we   = we_v[sel];
    m_addr = addr_v[sel];
    m_wd   = wd_v[sel];
    mx     = mx_v[sel];
    ci     = (sel == 2'd2) ? ci2 : (sel == 2'd1) ? {2'b00, ci1} : {2'b00, ci0};
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0][15:0] row(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [2:0][15:0] t3(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic vec_t mkvec(input int s, input int i_b, input int w_b, input int b_b,
                                 input int o_b, input logic [3:0][15:0] x,
                                 input logic [11:0][15:0] w, input logic [2:0][15:0] b,
                                 input logic [2:0][15:0] o, input int idx, input int mxv);
    vec_t v;
    v.sel = 2'(s);  v.ib = 16'(i_b); v.wb = 16'(w_b); v.bb = 16'(b_b); v.ob = 16'(o_b);
    v.x = x; v.w = w; v.b = b; v.o = o; v.idx = 2'(idx); v.mx = 16'(mxv);
    return v;
  endfunction

  // Called at a negedge; the word lands on the following posedge.
  task automatic poke(input logic [1:0] s, input logic [15:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_sel = s; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load_vec(input vec_t v);
    sel = v.sel; ib = v.ib; wb = v.wb; bb = v.bb; ob = v.ob;
    for (int i = 0; i < 4; i++)  poke(v.sel, v.ib + 16'(i), v.x[i]);
    for (int i = 0; i < 12; i++) poke(v.sel, v.wb + 16'(i), v.w[i]);
    for (int k = 0; k < 3; k++) begin
      poke(v.sel, v.bb + 16'(k), v.b[k]);
      poke(v.sel, v.ob + 16'(k), 16'hDEAD);
    end
  endtask

  // mode 0: plain run; 1: extra starts at cycles 3 and lat_exp plus base changes;
  // 2: return at cycle 12 with the run still in progress.
  task automatic run(input logic [1:0] s, input int mode, input int lat_exp,
                     output int lat, output int done_at);
    logic [15:0] sib, swb, sbb, sob;
    sib = ib; swb = wb; sbb = bb; sob = ob;
    sel = s; lat = 0; done_at = 0;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (!busy) break;
      lat++;
      if (done) done_at = lat;
      if (mode == 2 && lat == 12) break;
      if (mode == 1 && lat == 3) begin
        start_v[s] = 1'b1; ib = 16'h1111; wb = 16'h2222; bb = 16'h3333; ob = 16'h4444;
      end
      if (mode == 1 && lat == 4) start_v[s] = 1'b0;
      if (mode == 1 && lat == lat_exp) begin
        start_v[s] = 1'b1; ib = sib; wb = swb; bb = sbb; ob = sob;
      end
      @(negedge clk);
    end
    if (mode != 2) check($sformatf("run_end_busy_m%0d", mode), busy, 0);
  endtask

  task automatic verify(input vec_t v, input string tag, input int lat, input int dn);
    for (int k = 0; k < 3; k++)
      check($sformatf("%s_out%0d", tag, k), $signed(ram[v.sel][v.ob + 16'(k)]), $signed(v.o[k]));
    check({tag, "_class_idx"}, ci, v.idx);
    check({tag, "_max_value"}, $signed(mx), $signed(v.mx));
    check({tag, "_busy_cycles"}, lat, 27);
    check({tag, "_done_cycle"}, dn, 27);
  endtask

  vec_t vt [6];
  int   xs [120];
  int   ws [10][120];
  int   bs [10];

  initial begin
    int lat, dn, best, e, bidx;
    longint acc;

    // Element 0 of every row()/t3() is its first argument.
    vt[0] = mkvec(0, 100, 200, 300, 400, row(1, 2, 3, 4),
                  {row(2, 0, 0, 0), row(-1, 0, 0, 0), row(1, 1, 1, 1)},
                  t3(0, 5, -3), t3(10, 4, -1), 0, 10);
    vt[1] = mkvec(0, 100, 200, 300, 400, row(32767, 32767, 32767, 32767),
                  {row(0, 0, 0, 0), row(-32767, -32767, -32767, -32767),
                   row(32767, 32767, 32767, 32767)},
                  t3(0, 0, 0), t3(32767, -32768, 0), 0, 32767);
    vt[2] = mkvec(1, 100, 200, 300, 400, row(256, 0, 0, 0),
                  {row(512, 0, 0, 0), row(512, 0, 0, 0), row(512, 0, 0, 0)},
                  t3(1, 1, 1), t3(513, 513, 513), 0, 513);
    vt[3] = mkvec(0, 16'hFFFE, 600, 700, 800, row(1, -1, 2, 0),
                  {row(0, 0, 3, 0), row(1, 1, 1, 1), row(0, 0, 0, 0)},
                  t3(-7, -2, 1), t3(-7, 0, 7), 2, 7);
    vt[4] = mkvec(0, 100, 16'hFFF8, 300, 400, row(1, 1, 1, 1),
                  {row(0, 1, 0, 0), row(1, 0, 0, 0), row(0, 0, 0, 0)},
                  t3(-5, 3, 3), t3(-5, 4, 4), 1, 4);
    vt[5] = mkvec(1, 100, 200, 300, 400, row(384, 0, 0, 0),
                  {row(-32768, 0, 0, 0), row(1, 0, 0, 0), row(-1, 0, 0, 0)},
                  t3(0, 0, 0), t3(-2, 1, -32768), 1, 1);

    reset = 1'b1; ld_en = 1'b0; ld_sel = '0; ld_addr = '0; ld_data = '0; sel = '0;
    ib = '0; wb = '0; bb = '0; ob = '0;
    for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_class_idx", ci, 0);
    check("rst_max_value", mx, 0);
    check("rst_mem_en", m_en, 0);
    check("rst_mem_we", m_we, 0);
    check("rst_mem_addr", m_addr, 0);
    check("rst_mem_wdata", m_wd, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 6; n++) begin
      load_vec(vt[n]);
      run(vt[n].sel, 0, 27, lat, dn);
      verify(vt[n], $sformatf("vec%0d", n), lat, dn);
    end

    // Extra starts and base changes mid-run, then a start right after done.
    load_vec(vt[0]);
    run(2'd0, 1, 27, lat, dn);
    verify(vt[0], "proto_run1", lat, dn);
    run(2'd0, 0, 27, lat, dn);
    verify(vt[0], "proto_run2", lat, dn);

    // Asynchronous reset in the middle of a run.
    load_vec(vt[3]);
    run(2'd0, 2, 27, lat, dn);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_mem_en", m_en, 0);
    check("abort_mem_we", m_we, 0);
    check("abort_class_idx", ci, 0);
    check("abort_max_value", mx, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_out1_kept", ram[0][vt[3].ob + 16'd1], 16'hDEAD);
    check("abort_out2_kept", ram[0][vt[3].ob + 16'd2], 16'hDEAD);
    run(2'd0, 0, 27, lat, dn);
    verify(vt[3], "after_abort", lat, dn);

    // Default geometry with random data against a reference model.
    sel = 2'd2; ib = FC_IN_BASE; wb = FC_W_BASE; bb = FC_W_BASE + 16'd1200; ob = bb + 16'd10;
    for (int i = 0; i < 120; i++) begin
      xs[i] = int'($urandom_range(100)) - 50;
      poke(2'd2, ib + 16'(i), 16'(xs[i]));
    end
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < 120; i++) begin
        ws[j][i] = int'($urandom_range(100)) - 50;
        poke(2'd2, wb + 16'(j * 120 + i), 16'(ws[j][i]));
      end
      bs[j] = int'($urandom_range(4000)) - 2000;
      poke(2'd2, bb + 16'(j), 16'(bs[j]));
    end
    run(2'd2, 0, 1352, lat, dn);
    best = 0; bidx = 0;
    for (int j = 0; j < 10; j++) begin
      acc = longint'(bs[j]);
      for (int i = 0; i < 120; i++) acc += longint'(ws[j][i]) * longint'(xs[i]);
      if (acc > 32767)       e = 32767;
      else if (acc < -32768) e = -32768;
      else                   e = int'(acc);
      if (j == 0 || e > best) begin best = e; bidx = j; end
      check($sformatf("dflt_out%0d", j), $signed(ram[2][ob + 16'(j)]), e);
    end
    check("dflt_class_idx", ci, bidx);
    check("dflt_max_value", $signed(mx), best);
    check("dflt_busy_cycles", lat, 1352);
    check("dflt_done_cycle", dn, 1352);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fc_layer.md
# fc_layer

Fully-connected layer engine, downstream of the convolution/pooling controller. Once the last convolution layer has written its feature vector to RAM, `fc_layer` computes `out[j] = bias[j] + Σ_i W[j][i]·x[i]` for every output neuron and writes the results back to RAM. It also reports the index and value of the largest output (argmax, the classifier decision). It owns the RAM port while busy; arbitration with the DMA is external.

## Interface
Parameters:
- N_IN, 120, input vector length.
- N_OUT, 10, output neurons.
- FRAC, 0, fixed-point fraction bits. Products are shifted right by FRAC at writeback; 0 means plain integer arithmetic.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; ignored while busy.
- in_base  in  16  address of x[0]; sampled on accepted start.
- w_base  in  16  address of W[0][0]; row-major, W[j][i] at w_base + j·N_IN + i; sampled on start.
- b_base  in  16  address of bias[0]; sampled on start.
- out_base  in  16  address of out[0]; sampled on start.
- busy  out  1  high from accepted start through the done cycle.
- done  out  1  one-cycle pulse; class_idx and max_value are valid from this cycle.
- class_idx  out  $clog2(N_OUT)  argmax index; held until the next done.
- max_value  out  16  signed value at class_idx; held until the next done.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  write strobe (qualified by mem_en).
- mem_addr  out  16  unsigned word address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data, valid exactly one cycle after the read is issued.

## Operation
- All data are signed 16-bit. Each product is 32-bit. The accumulator is 40-bit signed, so no intermediate overflow is possible for N_IN ≤ 256.
- Bias alignment: the accumulator is initialised to sign-extended bias <<< FRAC.
- Writeback value = saturate16(acc >>> FRAC), clamped to [-32768, 32767].
- State machine states:
  - IDLE: on start, latch the base addresses, set i = j = 0, busy = 1, go to LOAD_X.
  - LOAD_X: issue reads in_base + k for k = 0..N_IN-1, one per cycle. The data returned one cycle later is captured into xbuf[k]. After the last issue, go to LOAD_WAIT.
  - LOAD_WAIT: capture xbuf[N_IN-1], then go to BIAS.
  - BIAS: issue a read of b_base + j.
  - MAC: for i = 0..N_IN-1, issue a read of W[j][i]. In the first MAC cycle, rdata is the bias and initialises acc. In each later cycle, acc += rdata·xbuf[i-1].
  - DRAIN: acc += rdata·xbuf[N_IN-1].
  - WRITE: mem_en = mem_we = 1, mem_addr = out_base + j, mem_wdata = saturated value. Update the argmax, then j++. Go to BIAS if j < N_OUT, otherwise DONE.
  - DONE: done = 1, then return to IDLE with busy = 0.
- Argmax: compare saturated values, strict greater-than, so ties resolve to the lowest index. Output 0 always seeds the running maximum.
- mem_en is 0 in IDLE, LOAD_WAIT, DRAIN and DONE. mem_we is 1 only in WRITE.

## Timing
- Reset values: busy = 0, done = 0, class_idx = 0, max_value = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. The FSM returns to IDLE.
- All outputs are registered.
- Latency: busy is high for exactly N_IN + 2 + N_OUT·(N_IN + 3) cycles, with done in the last of them. Defaults give 1352 cycles.
- Per-neuron cost is N_IN + 3 cycles, with one RAM access per cycle except DRAIN.
- start while busy: ignored, with no effect on latched addresses.
- start in the same cycle as done: ignored. A new start is accepted from IDLE on the next cycle.
- Reset mid-operation: immediate abort. No further RAM writes occur, already-written outputs remain in RAM, and class_idx/max_value are cleared.
- Address arithmetic wraps modulo 2^16.

## Structure
- Shared package cnn_pkg holds:
  - DATA_W = 16, ADDR_W = 16, ACC_W = 40;
  - the fc state enum;
  - function sat16(acc, frac);
  - default address constants FC_IN_BASE = 59596 and FC_W_BASE = 59716.
- One sub-module, fc_mac: 16×16 signed multiply plus 40-bit accumulate, with load (bias init), accumulate and clear controls. The FSM, xbuf (N_IN × 16 register array) and argmax stay in fc_layer.

## Test plan
Unless stated otherwise, cases use N_IN = 4, N_OUT = 3, FRAC = 0 and a behavioural RAM with 1-cycle read latency.
- Basic: x = [1, 2, 3, 4]; W rows [1, 1, 1, 1], [-1, 0, 0, 0], [2, 0, 0, 0]; bias [0, 5, -3] → RAM out = [10, 4, -1], class_idx = 0, max_value = 10; busy high exactly 27 cycles, done in cycle 27.
- Saturation: x = all 32767, W row 0 all 32767, row 1 all -32767, bias 0 → out[0] = 32767, out[1] = -32768.
- Tie and FRAC: FRAC = 8, x = [256, 0, 0, 0], W rows [512, 0, 0, 0] ×3, bias [1, 1, 1] → all outputs = 513 (512 + 1), class_idx = 0.
- Protocol: start pulsed again at cycles 3 and 27 → ignored. Base addresses changed mid-run → no effect. A start at cycle 28 begins a second identical run.
- Reset mid-MAC at cycle 12 → busy/mem_en drop at once, no write to out_base+1 or later, outputs at reset values. A subsequent start completes normally.
- Defaults (120→10) with random data vs. a reference model → all 10 outputs match, class_idx matches, latency 1352 cycles.
